sys_rst_seq: RTL and testbench

//  System-domain reset sequencer, directly downstream of the 80 MHz system PLL.

---
 rtl/sys_rst_seq.sv | 120 ++++++++++++
 tb/tb_sys_rst_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_rst_seq.sv
// System-domain reset sequencer: qualifies PLL lock, then releases reset domains
// one after another, and pulls them all back on lock loss or a software request.
module sys_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_DEBOUNCE = 256,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 16,
  parameter int SW_HOLD       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_stage,
  output logic                  rst_done,
  output logic [7:0]            lock_loss_cnt,
  output logic [2:0]            seq_state
);

  localparam int REL_SPAN  = (NUM_STAGES - 1) * STAGE_GAP;
  localparam int MAX_A     = (LOCK_DEBOUNCE > REL_SPAN + 1) ? LOCK_DEBOUNCE : REL_SPAN + 1;
  localparam int CNT_MAX   = (MAX_A > SW_HOLD) ? MAX_A : SW_HOLD;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  // Count value at which RUN is entered; a single stage still spends one cycle in RELEASE.
  localparam int LAST_EDGE = (NUM_STAGES == 1) ? 1 : REL_SPAN;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DEBOUNCE  = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign cnt_inc   = cnt + CNT_W'(1);
  assign seq_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      state         <= WAIT_LOCK;
      cnt           <= '0;
      rst_stage     <= '1;
      rst_done      <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      // Lock loss outranks everything, including a pending software request.
      if (state != WAIT_LOCK && !locked_s) begin
        state     <= WAIT_LOCK;
        cnt       <= '0;
        rst_stage <= '1;
        rst_done  <= 1'b0;
        if (state != DEBOUNCE && lock_loss_cnt != 8'hFF)
          lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end else begin
        case (state)
          WAIT_LOCK: begin
            cnt       <= '0;
            rst_stage <= '1;
            rst_done  <= 1'b0;
            if (locked_s)
              state <= DEBOUNCE;
          end
          DEBOUNCE: begin
            if (cnt == CNT_W'(LOCK_DEBOUNCE - 1)) begin
              state        <= RELEASE;
              cnt          <= '0;
              rst_stage[0] <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RELEASE: begin
            cnt <= cnt_inc;
            for (int k = 1; k < NUM_STAGES; k++)
              if (cnt_inc == CNT_W'(k * STAGE_GAP))
                rst_stage[k] <= 1'b0;
            if (cnt_inc == CNT_W'(LAST_EDGE)) begin
              state    <= RUN;
              rst_done <= 1'b1;
            end
          end
          RUN: begin
            if (sw_rst_req) begin
              state     <= HOLD;
              cnt       <= '0;
              rst_stage <= '1;
              rst_done  <= 1'b0;
            end
          end
          HOLD: begin
            // Lock is already qualified, so the hold goes straight back to staged release.
            if (cnt == CNT_W'(SW_HOLD - 1)) begin
              state        <= RELEASE;
              cnt          <= '0;
              rst_stage[0] <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_stage <= '1;
            rst_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_rst_seq.sv
// Bench for sys_rst_seq: timestamp-based reference model of the release schedule,
// randomized lock/sw stimulus, plus a short-debounce instance for counter saturation.
module tb_sys_rst_seq;

  localparam int SYNC = 2;
  localparam int LD   = 256;
  localparam int NS   = 3;
  localparam int GAP  = 16;
  localparam int SH   = 32;
  localparam int LAST = (NS == 1) ? 1 : (NS - 1) * GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_stage;
  logic       rst_done;
  logic [7:0] lock_loss_cnt;
  logic [2:0] seq_state;

  logic       pl2 = 1'b0;
  logic       sw2 = 1'b0;
  logic [2:0] stage2;
  logic       done2;
  logic [7:0] llc2;
  logic [2:0] st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sys_rst_seq #(.SYNC_STAGES(SYNC), .LOCK_DEBOUNCE(LD), .NUM_STAGES(NS),
                .STAGE_GAP(GAP), .SW_HOLD(SH)) u_dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .rst_stage(rst_stage), .rst_done(rst_done), .lock_loss_cnt(lock_loss_cnt),
    .seq_state(seq_state)
  );

  sys_rst_seq #(.SYNC_STAGES(2), .LOCK_DEBOUNCE(2), .NUM_STAGES(3),
                .STAGE_GAP(2), .SW_HOLD(2)) u_sat (
    .clk(clk), .rst(rst), .pll_locked(pl2), .sw_rst_req(sw2),
    .rst_stage(stage2), .rst_done(done2), .lock_loss_cnt(llc2), .seq_state(st2)
  );

  // Reference model: events are recorded as edge timestamps; outputs follow by arithmetic.
  int         t = 0;
  int         lock_edge, rel_start, hold_start, m_loss;
  bit         sh [SYNC];
  logic [2:0] exp_stage;
  logic       exp_done;
  logic [7:0] exp_llc;
  logic [2:0] exp_state;

  function automatic int state_at(int tt);
    if (hold_start >= 0) return 4;
    if (rel_start >= 0)  return (tt >= rel_start + LAST) ? 3 : 2;
    if (lock_edge >= 0)  return 1;
    return 0;
  endfunction

  task automatic model_outputs();
    int         r;
    logic [2:0] ones;
    ones = '1;
    r = 0;
    if (rel_start >= 0) begin
      r = (t - rel_start) / GAP + 1;
      if (r > NS) r = NS;
    end
    exp_stage = ones << r;
    exp_state = 3'(state_at(t));
    exp_done  = (state_at(t) == 3);
    exp_llc   = 8'(m_loss);
  endtask

  task automatic model_reset();
    lock_edge  = -1;
    rel_start  = -1;
    hold_start = -1;
    m_loss     = 0;
    for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
    model_outputs();
  endtask

  task automatic apply_reset();
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit pl, input bit sw);
    int pre;
    bit ls;
    pll_locked = pl;
    sw_rst_req = sw;
    @(posedge clk);
    pre = state_at(t);
    ls  = sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = pl;
    t++;
    if (pre == 0) begin
      if (ls) lock_edge = t;
    end else if (!ls) begin
      if (pre >= 2 && m_loss < 255) m_loss++;
      lock_edge  = -1;
      rel_start  = -1;
      hold_start = -1;
    end else if (pre == 1) begin
      if (t - lock_edge == LD) begin
        rel_start = t;
        lock_edge = -1;
      end
    end else if (pre == 3) begin
      if (sw) begin
        hold_start = t;
        rel_start  = -1;
      end
    end else if (pre == 4) begin
      if (t - hold_start == SH) begin
        rel_start  = t;
        hold_start = -1;
      end
    end
    model_outputs();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {3'b111, 1'b0, 8'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got %b/%b/%0d/%0d exp 111/0/0/0", rst_stage, rst_done, lock_loss_cnt, seq_state);
    end
    checks++;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL reset_idle t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
    end
  endtask

  task automatic test_lock_once();
    apply_reset();
    for (int e = 1; e <= 320; e++) begin
      step(1'b1, 1'b0);
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL lock_once t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
      if (e == 258 || e == 259 || e == 275 || e == 291) begin
        if ({rst_stage, rst_done} !== ((e == 258) ? 4'b1110 : (e == 259) ? 4'b1100 :
                                       (e == 275) ? 4'b1000 : 4'b0001)) begin
          errors++;
          $display("FAIL lock_once_edge%0d got stage=%b done=%b", e, rst_stage, rst_done);
        end
        checks++;
      end
    end
  endtask

  task automatic test_debounce_abort();
    apply_reset();
    for (int i = 0; i < 405; i++) begin
      step((i < 100 || i >= 105), 1'b0);
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL debounce_abort t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
      if (i == 105 + 257 || i == 105 + 258) begin
        if ({rst_stage, lock_loss_cnt} !== ((i == 105 + 257) ? {3'b111, 8'd0} : {3'b110, 8'd0})) begin
          errors++;
          $display("FAIL debounce_abort_edge got stage=%b llc=%0d at step %0d", rst_stage, lock_loss_cnt, i);
        end
        checks++;
      end
    end
  endtask

  task automatic test_lock_loss_run();
    int low;
    apply_reset();
    low = $urandom_range(3, 20);
    for (int i = 0; i < 300 + low + 300; i++) begin
      step(!(i >= 300 && i < 300 + low), 1'b0);
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL lock_loss_run t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
      if (i == 302) begin
        if ({rst_stage, rst_done, lock_loss_cnt} !== {3'b111, 1'b0, 8'd1}) begin
          errors++;
          $display("FAIL lock_loss_latency got stage=%b done=%b llc=%0d exp 111/0/1", rst_stage, rst_done, lock_loss_cnt);
        end
        checks++;
      end
    end
    if ({rst_stage, rst_done, lock_loss_cnt} !== {3'b000, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL lock_loss_relock got stage=%b done=%b llc=%0d exp 000/1/1", rst_stage, rst_done, lock_loss_cnt);
    end
    checks++;
  endtask

  task automatic test_sw_reset();
    int extra;
    apply_reset();
    extra = $urandom_range(0, 20);
    for (int i = 0; i < 300 + extra; i++) step(1'b1, 1'b0);
    for (int k = 0; k <= 80; k++) begin
      step(1'b1, k == 0);
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL sw_reset t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
      if (k == 31 || k == 32 || k == 48 || k == 64) begin
        if ({rst_stage, rst_done, lock_loss_cnt} !== {((k == 31) ? 3'b111 : (k == 32) ? 3'b110 :
                                                       (k == 48) ? 3'b100 : 3'b000), k == 64, 8'd0}) begin
          errors++;
          $display("FAIL sw_reset_k%0d got stage=%b done=%b llc=%0d", k, rst_stage, rst_done, lock_loss_cnt);
        end
        checks++;
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    if ({seq_state, rst_stage, lock_loss_cnt} !== {3'd0, 3'b111, 8'd1}) begin
      errors++;
      $display("FAIL priority_loss_vs_sw got state=%0d stage=%b llc=%0d exp 0/111/1", seq_state, rst_stage, lock_loss_cnt);
    end
    checks++;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    if ({seq_state, rst_stage} !== {3'd1, 3'b111}) begin
      errors++;
      $display("FAIL sw_in_debounce got state=%0d stage=%b exp 1/111", seq_state, rst_stage);
    end
    checks++;
    for (int i = 0; i < 320; i++) begin
      step(1'b1, ($urandom_range(0, 49) == 0));
      if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
        errors++;
        $display("FAIL priority_tail t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int n;
    int len;
    bit lvl;
    apply_reset();
    n = 0;
    lvl = 1'b0;
    while (n < 2500) begin
      lvl = ~lvl;
      len = lvl ? $urandom_range(1, 380) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        step(lvl, ($urandom_range(0, 29) == 0));
        if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {exp_stage, exp_done, exp_llc, exp_state}) begin
          errors++;
          $display("FAIL random t=%0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", t, rst_stage, rst_done, lock_loss_cnt, seq_state, exp_stage, exp_done, exp_llc, exp_state);
        end
        checks++;
        n++;
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    apply_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    budget = 0;
    while (rel_start < 0 && budget < 400) begin
      step(1'b1, 1'b0);
      budget++;
    end
    if (rel_start < 0) begin
      errors++;
      $display("FAIL async_reset_setup no release within budget");
    end
    checks++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    if ({rst_stage, lock_loss_cnt, seq_state} !== {3'b110, 8'd1, 3'd2}) begin
      errors++;
      $display("FAIL async_reset_pre got stage=%b llc=%0d state=%0d exp 110/1/2", rst_stage, lock_loss_cnt, seq_state);
    end
    checks++;
    #3;
    rst = 1'b1;
    #1;
    if ({rst_stage, rst_done, lock_loss_cnt, seq_state} !== {3'b111, 1'b0, 8'd0, 3'd0}) begin
      errors++;
      $display("FAIL async_reset got %b/%b/%0d/%0d exp 111/0/0/0", rst_stage, rst_done, lock_loss_cnt, seq_state);
    end
    checks++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    int exp_sat;
    apply_reset();
    for (int i = 1; i <= 300; i++) begin
      pl2 = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      pl2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exp_sat = (i > 255) ? 255 : i;
      if (llc2 !== 8'(exp_sat)) begin
        errors++;
        $display("FAIL saturation loss%0d got llc=%0d exp %0d", i, llc2, exp_sat);
      end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_once();
    test_debounce_abort();
    test_lock_loss_run();
    test_sw_reset();
    test_priority();
    test_random();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
